// File: rtl/conversor_bcd_pkg.sv
// Shared types, sizes and the nibble-wise add-3 correction for the
// binary-to-BCD result converter.
package conversor_bcd_pkg;

  localparam int BCD_WIDTH  = 7;
  localparam int BCD_DIGITS = 3;
  localparam int CNT_W      = $clog2(BCD_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Each nibble is corrected on its own; a nibble >= 5 cannot overflow 4 bits.
  function automatic logic [4*BCD_DIGITS-1:0] add3_nibbles(
    input logic [4*BCD_DIGITS-1:0] v
  );
    logic [4*BCD_DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/conversor_bcd_resultado_step.sv
// One double-dabble iteration: add-3 correction on the BCD part, then shift
// the whole {bcd, binary} vector left by one.
module bcd_dabble_step
  import conversor_bcd_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic [4*DIGITS+WIDTH-1:0] vec_i,
  output logic [4*DIGITS+WIDTH-1:0] vec_o
);

  logic [4*DIGITS+WIDTH-1:0] corr;

  assign corr  = {add3_nibbles(vec_i[4*DIGITS+WIDTH-1:WIDTH]), vec_i[WIDTH-1:0]};
  assign vec_o = {corr[4*DIGITS+WIDTH-2:0], 1'b0};

endmodule

// File: rtl/conversor_bcd_resultado.sv
// Latches quotient/remainder on start and converts both to BCD, one bit per clock.
// state | meaning: IDLE wait for start | CONV one shift per clock | FIN publish result
module conversor_bcd_resultado
  import conversor_bcd_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      cociente,
  input  logic [WIDTH-1:0]      resto,
  output logic [4*DIGITS-1:0]   bcd_q,
  output logic [4*DIGITS-1:0]   bcd_r,
  output logic                  busy,
  output logic                  done
);

  localparam int SW = 4*DIGITS + WIDTH;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]       shq_q, shq_d, shr_q, shr_d;
  logic [SW-1:0]       stepq, stepr;
  logic [4*DIGITS-1:0] bcdq_q, bcdq_d, bcdr_q, bcdr_d;
  logic                done_q, done_d;

  bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_step_q (
    .vec_i (shq_q),
    .vec_o (stepq)
  );

  bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_step_r (
    .vec_i (shr_q),
    .vec_o (stepr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shq_d   = shq_q;
    shr_d   = shr_q;
    bcdq_d  = bcdq_q;
    bcdr_d  = bcdr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shq_d   = {{(4*DIGITS){1'b0}}, cociente};
          shr_d   = {{(4*DIGITS){1'b0}}, resto};
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        shq_d = stepq;
        shr_d = stepr;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIN;
      end
      FIN: begin
        bcdq_d  = shq_q[SW-1:WIDTH];
        bcdr_d  = shr_q[SW-1:WIDTH];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shq_q   <= '0;
      shr_q   <= '0;
      bcdq_q  <= '0;
      bcdr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shq_q   <= shq_d;
      shr_q   <= shr_d;
      bcdq_q  <= bcdq_d;
      bcdr_q  <= bcdr_d;
      done_q  <= done_d;
    end
  end

  assign bcd_q = bcdq_q;
  assign bcd_r = bcdr_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

endmodule
